// File: rtl/meteor_controller.sv
// meteor_controller: spawns, moves and retires six meteor slots and halts the game on a collision.
module meteor_controller #(
  parameter int         SCREEN_W       = 640,
  parameter int         SCREEN_H       = 480,
  parameter int         METEOR_SIZE    = 30,
  parameter int         METEOR_SPEED   = 2,
  parameter int         SPAWN_INTERVAL = 30,
  parameter logic [9:0] LFSR_SEED      = 10'h2A5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_tick,
  input  logic            start,
  input  logic [5:0]      meteor_collisions,
  output logic [5:0][9:0] meteor_x,
  output logic [5:0][8:0] meteor_y,
  output logic [5:0]      meteor_active,
  output logic            running,
  output logic            halted,
  output logic [15:0]     dodged_count
);
  localparam int CW = $clog2(SPAWN_INTERVAL + 1);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
  state_e          state_q, state_d;
  logic [5:0][9:0] x_q, x_d;
  logic [5:0][8:0] y_q, y_d;
  logic [5:0]      act_q, act_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      lfsr_q, lfsr_d;
  logic [15:0]     dodged_q, dodged_d;
  logic [9:0]      y_next;
  logic [2:0]      exits, sel;
  logic            hit, attempt;
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    dodged_d = dodged_q;
    y_next   = '0;
    exits    = '0;
    sel      = '0;
    hit      = |(meteor_collisions & act_q);
    attempt  = cnt_q == CW'(SPAWN_INTERVAL - 1);
    // spawn target is chosen from occupancy at the start of the cycle, so a slot freed this tick waits
    for (int i = 5; i >= 0; i--) if (!act_q[i]) sel = 3'(i);
    if (start) begin
      state_d  = RUN;
      x_d      = '0;
      y_d      = '0;
      act_d    = '0;
      cnt_d    = '0;
      dodged_d = '0;
    end else if (state_q == RUN && hit) begin
      state_d = HALT;
    end else if (state_q == RUN && frame_tick) begin
      for (int i = 0; i < 6; i++) begin
        if (act_q[i]) begin
          y_next = 10'(y_q[i]) + 10'(METEOR_SPEED);
          if (y_next >= 10'(SCREEN_H)) begin
            act_d[i] = 1'b0;
            y_d[i]   = '0;
            exits    = exits + 3'd1;
          end else begin
            y_d[i] = y_next[8:0];
          end
        end
      end
      dodged_d = dodged_q + 16'(exits);
      cnt_d    = attempt ? '0 : cnt_q + CW'(1);
      if (attempt && !(&act_q)) begin
        act_d[sel] = 1'b1;
        y_d[sel]   = '0;
        x_d[sel]   = lfsr_q < 10'(SCREEN_W - METEOR_SIZE) ? lfsr_q : lfsr_q - 10'd512;
        lfsr_d     = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      act_q    <= '0;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      dodged_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      dodged_q <= dodged_d;
    end
  end
  assign meteor_x      = x_q;
  assign meteor_y      = y_q;
  assign meteor_active = act_q;
  assign running       = state_q == RUN;
  assign halted        = state_q == HALT;
  assign dodged_count  = dodged_q;
endmodule

// File: tb/tb_meteor_controller.sv
// tb_meteor_controller: directed scoreboard bench over three parameterisations of meteor_controller.
module tb_meteor_controller;
  logic clk = 0, reset = 0, frame_tick = 0, start = 0;
  logic [5:0] coll = '0;
  logic [5:0][9:0] xa, xb, xc;
  logic [5:0][8:0] ya, yb, yc;
  logic [5:0] aa, ab, ac;
  logic ra, rb, rc, ha, hb, hc;
  logic [15:0] da, db, dc;
  logic [5:0][9:0] ex;
  logic [5:0][8:0] ey;
  int tests = 0, fails = 0;
  string tag_q[$];
  logic [63:0] exp_q[$];

  meteor_controller dut_a (.clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .meteor_collisions(coll), .meteor_x(xa), .meteor_y(ya), .meteor_active(aa),
    .running(ra), .halted(ha), .dodged_count(da));
  meteor_controller #(.SPAWN_INTERVAL(250)) dut_b (.clk(clk), .reset(reset), .frame_tick(frame_tick),
    .start(start), .meteor_collisions(6'b0), .meteor_x(xb), .meteor_y(yb), .meteor_active(ab),
    .running(rb), .halted(hb), .dodged_count(db));
  meteor_controller #(.SPAWN_INTERVAL(1), .METEOR_SPEED(1)) dut_c (.clk(clk), .reset(reset),
    .frame_tick(frame_tick), .start(start), .meteor_collisions(6'b0), .meteor_x(xc), .meteor_y(yc),
    .meteor_active(ac), .running(rc), .halted(hc), .dodged_count(dc));

  always #5 clk = ~clk;

  task automatic push(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1;
      step();
      frame_tick = 0;
    end
  endtask

  task automatic do_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic reset_a_checked(input string p);
    push({p, "_act"}, 0); push({p, "_x"}, 0); push({p, "_y"}, 0);
    push({p, "_run"}, 0); push({p, "_halt"}, 0); push({p, "_dodged"}, 0);
    reset = 1;
    step();
    reset = 0;
    chk(aa); chk(xa); chk(ya); chk(ra); chk(ha); chk(da);
  endtask

  initial begin
    reset_a_checked("rst");
    push("start_run", 1); push("start_act", 0);
    do_start();
    chk(ra); chk(aa);
    push("pre_spawn_act", 0);
    ticks(29);
    chk(aa);
    push("spawn1_act", 1); push("spawn1_x", 165); push("spawn1_y", 0);
    ticks(1);
    chk(aa); chk(xa[0]); chk(ya[0]);
    push("move_y", 2); push("inactive_hit_run", 1);
    coll = 6'b100000;
    ticks(1);
    coll = '0;
    chk(ya[0]); chk(ra);
    push("pre_spawn2_act", 1); push("pre_spawn2_y", 58);
    ticks(28);
    chk(aa); chk(ya[0]);
    push("spawn2_act", 3); push("spawn2_x", 331); push("spawn2_y0", 60);
    ticks(1);
    chk(aa); chk(xa[1]); chk(ya[0]);
    push("hit_halt", 1); push("hit_run", 0); push("hit_y", 60);
    coll = 6'b000001;
    frame_tick = 1;
    step();
    coll = '0;
    frame_tick = 0;
    chk(ha); chk(ra); chk(ya);
    ex = '0; ex[0] = 165; ex[1] = 331;
    push("halt_y", 60); push("halt_x", ex); push("halt_act", 3); push("halt_dodged", 0); push("halt_halt", 1);
    ticks(10);
    chk(ya); chk(xa); chk(aa); chk(da); chk(ha);
    push("restart_act", 0); push("restart_x", 0); push("restart_y", 0);
    push("restart_dodged", 0); push("restart_run", 1); push("restart_halt", 0);
    do_start();
    chk(aa); chk(xa); chk(ya); chk(da); chk(ra); chk(ha);
    push("noreseed_x", 151); push("noreseed_act", 1);
    ticks(30);
    chk(xa[0]); chk(aa);
    push("three_act", 7);
    ticks(60);
    chk(aa);
    reset_a_checked("midrst");
    push("again_x", 165);
    do_start();
    ticks(30);
    chk(xa[0]);

    reset = 1; step(); reset = 0;
    do_start();
    push("b_spawn_act", 1); push("b_spawn_x", 165);
    ticks(250);
    chk(ab); chk(xb[0]);
    push("b_last_y", 478); push("b_last_act", 1); push("b_last_dodged", 0);
    ticks(239);
    chk(yb[0]); chk(ab); chk(db);
    push("b_exit_act", 0); push("b_exit_y", 0); push("b_exit_x", 165); push("b_exit_dodged", 1);
    ticks(1);
    chk(ab); chk(yb[0]); chk(xb[0]); chk(db);

    reset = 1; step(); reset = 0;
    do_start();
    ex[0] = 165; ex[1] = 331; ex[2] = 151; ex[3] = 303; ex[4] = 606; ex[5] = 188;
    for (int i = 0; i < 6; i++) ey[i] = 9'(5 - i);
    push("c_full_act", 6'h3F); push("c_full_x", ex); push("c_full_y", ey);
    ticks(6);
    chk(ac); chk(xc); chk(yc);
    push("c_skip_act", 6'h3F); push("c_skip_x", ex); push("c_skip_y0", 6);
    ticks(1);
    chk(ac); chk(xc); chk(yc[0]);
    push("c_edge_y0", 479); push("c_edge_act", 6'h3F); push("c_edge_dodged", 0);
    ticks(473);
    chk(yc[0]); chk(ac); chk(dc);
    push("c_exit_act", 6'b111110); push("c_exit_dodged", 1); push("c_exit_x0", 165); push("c_exit_y0", 0);
    ticks(1);
    chk(ac); chk(dc); chk(xc[0]); chk(yc[0]);
    push("c_reuse_act", 6'b111101); push("c_reuse_x0", 376); push("c_reuse_y0", 0); push("c_reuse_dodged", 2);
    ticks(1);
    chk(ac); chk(xc[0]); chk(yc[0]); chk(dc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/meteor_controller.md
Name: meteor_controller

Overview:
- Upstream producer of the meteor state consumed by collision_detector. Owns six meteor slots: spawns meteors at pseudo-random x positions, moves them down one step per frame and retires them when they leave the screen.
- Consumes collision_detector's meteor_collisions to halt the game on a hit. Counts dodged meteors for the score display.

Parameters:
- SCREEN_W, 640, screen width in pixels
- SCREEN_H, 480, screen height in pixels
- METEOR_SIZE, 30, meteor square side in pixels
- METEOR_SPEED, 2, pixels moved down per frame_tick (1..15)
- SPAWN_INTERVAL, 30, frame_ticks between spawn attempts (>=1)
- LFSR_SEED, 10'h2A5, LFSR reset value (non-zero)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse: begin a new game
- meteor_collisions  in  6  per-slot hit flags from collision_detector
- meteor_x  out  10 x [5:0]  slot x positions (left edge)
- meteor_y  out  9 x [5:0]  slot y positions (top edge)
- meteor_active  out  6  slot valid flags
- running  out  1  FSM in RUN
- halted  out  1  FSM in HALT
- dodged_count  out  16  meteors retired off-screen this game

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset has priority over all inputs.
  - Reset values: meteor_x/meteor_y all 0, meteor_active=0, dodged_count=0, spawn counter=0, LFSR=LFSR_SEED, state=IDLE (running=0, halted=0).
- FSM states: IDLE, RUN, HALT.
  - IDLE: start -> RUN. Slots stay inactive.
  - RUN: a hit is (meteor_collisions & meteor_active) != 0 in any cycle. A hit moves the FSM to HALT on the next edge. In that same cycle there is no move, spawn or counter update, even if frame_tick=1.
  - HALT: all registers frozen; frame_tick is ignored.
  - start in HALT or RUN: clears all slots to 0/inactive, dodged_count=0, spawn counter=0, and moves to RUN. The LFSR is not reseeded.
  - start has priority over a same-cycle hit.
- Per frame_tick in RUN (no hit):
  - Move: each active slot computes y_next = y + METEOR_SPEED in 10 bits.
    - If y_next >= SCREEN_H: slot is cleared (active=0, y=0, x unchanged) and dodged_count increments by the number of slots retired this tick. dodged_count wraps at 65535.
    - Otherwise y <= y_next.
  - Spawn counter counts 0..SPAWN_INTERVAL-1. A spawn attempt occurs on the tick where the counter == SPAWN_INTERVAL-1; the counter then returns to 0. The first attempt is on the SPAWN_INTERVAL-th tick after start.
  - Spawn target: the lowest-index slot that is inactive at the start of the cycle. A slot freed by an exit in the same tick is not reused until a later tick.
  - If all six slots are active, the attempt is skipped and the LFSR does not advance.
  - Spawned slot: active=1, y=0, x = L if L < SCREEN_W-METEOR_SIZE (610), else x = L-512. L is the current LFSR value.
  - The LFSR advances only on a successful spawn, after its value is used.
- LFSR: 10-bit Fibonacci, next = {q[8:0], q[9]^q[6]}.
- All outputs are registered. Positions change one cycle after the qualifying frame_tick.
- Reset mid-game returns to IDLE with reset values; the next start behaves as the first.

Test Plan:
- Reset, then start, then 30 frame_ticks -> slot 0 active, x=165 (677-512), y=0; other slots inactive; running=1.
- Continue to a second spawn -> slot 1 spawns with x=331; during this period slot 0 y advances by 2 per tick.
- One meteor from y=0, 240 frame_ticks with SPAWN_INTERVAL set large -> slot y=478 after tick 239; after tick 240 the slot is inactive, y=0, dodged_count=1.
- meteor_collisions[0]=1 with active[0]=1, frame_tick in the same cycle -> next cycle halted=1 and the position is unchanged; 10 further frame_ticks leave all outputs constant; start -> all inactive, dodged_count=0, running=1.
- Fill all six slots (SPAWN_INTERVAL=1, METEOR_SPEED=1) -> the 7th attempt is skipped, the LFSR holds, and the next spawn reuses the first freed slot one tick after it exits.
- Assert reset mid-RUN with three active slots -> next cycle all outputs equal reset values; start and 30 ticks reproduce x=165.
